// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the 7-segment scan path: segment patterns (active-low abcdefg),
// one-hot-low anode selects, digit port widths and the sampler state type.
package seg_scan_decoder_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_H1 = 4'b0111;
  localparam logic [3:0] AN_H2 = 4'b1011;
  localparam logic [3:0] AN_M1 = 4'b1101;
  localparam logic [3:0] AN_M2 = 4'b1110;

  localparam int unsigned H1_W = 2;
  localparam int unsigned H2_W = 4;
  localparam int unsigned M1_W = 3;
  localparam int unsigned M2_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLING,
    SAMPLED
  } scan_state_t;

  // Values double as the digit's bit position in the capture mask.
  typedef enum logic [1:0] {
    DIG_M2 = 2'd0,
    DIG_M1 = 2'd1,
    DIG_H2 = 2'd2,
    DIG_H1 = 2'd3
  } digit_t;

endpackage

// File: rtl/seg_scan_decoder_pattern_decode.sv
// Combinational 7-segment pattern to BCD decoder; valid is low for any unrecognised pattern.
module seg_pattern_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       valid,
  output logic [3:0] bcd
);

  always_comb begin
    valid = 1'b1;
    bcd   = '0;
    case (pattern)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of the multiplexed 7-segment bus: settles on each scanned anode, samples and
// decodes the digit, assembles H1/H2/M1/M2 frames and flags pattern, range and stall errors.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] segments,
  input  logic [3:0] anode_active,
  output logic [1:0] H1,
  output logic [3:0] H2,
  output logic [2:0] M1,
  output logic [3:0] M2,
  output logic       frame_valid,
  output logic       frame_changed,
  output logic       pattern_err,
  output logic       range_err,
  output logic       scan_stall
);

  localparam int unsigned CNT_W = $clog2(SETTLE + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [TO_W-1:0]  TO_MAX      = TO_W'(TIMEOUT);

  scan_state_t      state, state_next;
  logic [3:0]       anode_prev;
  logic [CNT_W-1:0] settle_cnt, settle_next;
  logic             an_valid;
  digit_t           an_digit;
  logic             same;
  logic             sample;
  logic             capture;
  logic             dec_valid;
  logic [3:0]       dec_bcd;
  logic [3:0]       shadow [4];
  logic [3:0]       mask;
  logic [TO_W-1:0]  to_cnt;
  logic             have_frame;
  logic [12:0]      new_frame;
  logic             new_range;

  seg_pattern_decode u_decode (
    .pattern (segments),
    .valid   (dec_valid),
    .bcd     (dec_bcd)
  );

  always_comb begin
    an_valid = 1'b1;
    an_digit = DIG_M2;
    case (anode_active)
      AN_H1:   an_digit = DIG_H1;
      AN_H2:   an_digit = DIG_H2;
      AN_M1:   an_digit = DIG_M1;
      AN_M2:   an_digit = DIG_M2;
      default: an_valid = 1'b0;
    endcase
  end

  // A sample fires on the edge the counter reaches SETTLE-1, i.e. after SETTLE consecutive
  // edges on one anode; SAMPLED blocks re-sampling for the rest of the dwell.
  always_comb begin
    same        = an_valid && (anode_active == anode_prev);
    settle_next = '0;
    if (same) begin
      settle_next = (settle_cnt == SETTLE_LAST) ? settle_cnt : settle_cnt + CNT_W'(1);
    end
    sample     = an_valid && (!same || state != SAMPLED) && (settle_next == SETTLE_LAST);
    state_next = state;
    if (!an_valid) begin
      state_next = IDLE;
    end else if (sample) begin
      state_next = SAMPLED;
    end else if (!same) begin
      state_next = SETTLING;
    end
  end

  assign capture   = sample && dec_valid;
  assign new_frame = {shadow[DIG_H1][1:0], shadow[DIG_H2], shadow[DIG_M1][2:0], shadow[DIG_M2]};
  assign new_range = (shadow[DIG_H1] > 4'd2) || (shadow[DIG_M1] > 4'd5) ||
                     ((shadow[DIG_H1] == 4'd2) && (shadow[DIG_H2] > 4'd3));
  assign scan_stall = (to_cnt == TO_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      anode_prev    <= '1;
      settle_cnt    <= '0;
      mask          <= '0;
      to_cnt        <= '0;
      have_frame    <= 1'b0;
      H1            <= '0;
      H2            <= '0;
      M1            <= '0;
      M2            <= '0;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      pattern_err   <= 1'b0;
      range_err     <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      state         <= state_next;
      anode_prev    <= anode_active;
      settle_cnt    <= settle_next;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;

      if (sample && !dec_valid) begin
        pattern_err <= 1'b1;
      end
      if (capture) begin
        shadow[an_digit] <= dec_bcd;
      end

      // Completion reads the pre-edge shadows and mask; a same-edge capture lands in the
      // cleared mask and in the shadows for the next frame.
      if (mask == '1) begin
        {H1, H2, M1, M2} <= new_frame;
        frame_valid      <= 1'b1;
        frame_changed    <= !have_frame || (new_frame != {H1, H2, M1, M2});
        have_frame       <= 1'b1;
        range_err        <= new_range;
      end
      mask <= ((mask == '1) ? 4'b0000 : mask) | (capture ? (4'b0001 << an_digit) : 4'b0000);

      if (capture) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

endmodule
